ray_scheduler: RTL

Sequences the per-column ray-cast datapath. Replaces the single-cycle all-columns cast with an issue/collect scheduler. On a frame strobe it generates one normalized ray angle per screen column and issues it to a pipelined ray-cast unit over a valid/ready handshake. It collects the tagged results and writes them into the back half of a double-buffered line store, then swaps buffers so the renderer always reads a complete frame.

---
 rtl/raycast_pkg.sv | 30 +++
 rtl/ray_angle_gen.sv | 57 +++++
 rtl/ray_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/raycast_pkg.sv
// Shared types and constants for the ray-cast scheduling path.
// Angles are Q16.16 fixed point in [0, TWO_PI).
package raycast_pkg;

    typedef logic signed [31:0] fix_t;

    typedef struct packed {
        logic is_vert;
        fix_t height;
    } line_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_SWAP  = 2'd3
    } sched_state_e;

    localparam int   H_RES    = 640;
    localparam int   COL_W    = 10;
    localparam fix_t TWO_PI   = 32'sd411774;
    localparam fix_t FOV_HALF = 32'sd34314;
    localparam fix_t FOV_STEP = 32'sd107;

    // Elaboration-time conversion of a real constant to Q16.16 (truncating).
    function automatic fix_t to_fix(input real x);
        return fix_t'($rtoi(x * 65536.0));
    endfunction

endpackage

// File: rtl/ray_angle_gen.sv
// Per-column ray angle accumulator with wrap into [0, WRAP) and the column counter.
// load_i seeds angle = angle_i - HALF (wrapped); step_i advances one column.
module ray_angle_gen
    import raycast_pkg::*;
#(
    parameter int   N_COLS = H_RES,
    parameter fix_t STEP   = FOV_STEP,
    parameter fix_t HALF   = FOV_HALF,
    parameter fix_t WRAP   = TWO_PI
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [31:0]      angle_i,
    output logic [31:0]      angle_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [31:0]      angle_q, angle_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [32:0]      start_w;
    logic [32:0]      sum_w;

    // 33-bit arithmetic: bit 32 of start_w is the borrow (negative start),
    // and sum_w is compared at full width before any truncation.
    assign start_w = {angle_i[31], angle_i} - {HALF[31], HALF};
    assign sum_w   = {1'b0, angle_q} + {1'b0, STEP};

    always_comb begin
        angle_d = angle_q;
        col_d   = col_q;
        if (load_i) begin
            angle_d = start_w[32] ? (start_w[31:0] + WRAP) : start_w[31:0];
            col_d   = '0;
        end else if (step_i) begin
            angle_d = (sum_w >= {1'b0, WRAP}) ? (sum_w[31:0] - WRAP) : sum_w[31:0];
            col_d   = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            angle_q <= '0;
            col_q   <= '0;
        end else begin
            angle_q <= angle_d;
            col_q   <= col_d;
        end
    end

    assign angle_o = angle_q;
    assign col_o   = col_q;
    assign last_o  = (col_q == COL_W'(N_COLS - 1));

endmodule

// File: rtl/ray_scheduler.sv
// Issue/collect scheduler: one ray per column to a pipelined caster, tagged
// results written into the back half of a double-buffered line store.
//
// Handshake: a request transfers on any rising clk_in where ray_valid_out and
// ray_ready_in are both high; angle/column only change on a transfer. Results
// have no backpressure and are written in the cycle res_valid_in is high.
module ray_scheduler
    import raycast_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_in,
    input  logic        dirty_in,
    input  logic [31:0] angle_in,
    output logic        ray_valid_out,
    input  logic        ray_ready_in,
    output logic [31:0] ray_angle_out,
    output logic [9:0]  ray_col_out,
    input  logic        res_valid_in,
    input  logic [9:0]  res_col_in,
    input  logic        res_is_vert_in,
    input  logic [31:0] res_height_in,
    output logic        wr_en_out,
    output logic [10:0] wr_addr_out,
    output logic [32:0] wr_data_out,
    output logic        buf_sel_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        overrun_out
);

    localparam int IF_W  = 4;
    localparam int CNT_W = $clog2(H_RES + 1);

    sched_state_e     state_q, state_d;
    logic [IF_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
    logic             force_q, force_d;
    logic             buf_sel_q, buf_sel_d;
    logic             overrun_q, overrun_d;

    logic             start_w;
    logic             hs_w;
    logic             res_acc_w;
    logic             last_col_w;
    line_t            wr_line_w;

    assign start_w       = (state_q == S_IDLE) && frame_in && (dirty_in || force_q);
    assign ray_valid_out = (state_q == S_ISSUE) && (inflight_q < IF_W'(MAX_INFLIGHT));
    assign hs_w          = ray_valid_out && ray_ready_in;
    // A result with nothing outstanding, or outside a render, is dropped.
    assign res_acc_w     = res_valid_in && (inflight_q != '0)
                         && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

    ray_angle_gen #(
        .N_COLS(H_RES),
        .STEP  (FOV_STEP),
        .HALF  (FOV_HALF),
        .WRAP  (TWO_PI)
    ) u_angle_gen (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .load_i (start_w),
        .step_i (hs_w),
        .angle_i(angle_in),
        .angle_o(ray_angle_out),
        .col_o  (ray_col_out),
        .last_o (last_col_w)
    );

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        recv_cnt_d = recv_cnt_q;
        force_d    = force_q;
        buf_sel_d  = buf_sel_q;
        overrun_d  = overrun_q || (frame_in && (state_q != S_IDLE));

        if (hs_w && !res_acc_w) begin
            inflight_d = inflight_q + IF_W'(1);
        end else if (!hs_w && res_acc_w) begin
            inflight_d = inflight_q - IF_W'(1);
        end
        if (res_acc_w) begin
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d    = S_ISSUE;
                    recv_cnt_d = '0;
                    force_d    = 1'b0;
                end
            end
            S_ISSUE: begin
                if (hs_w && last_col_w) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_acc_w && (recv_cnt_q == CNT_W'(H_RES - 1))) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                buf_sel_d = ~buf_sel_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            inflight_q <= '0;
            recv_cnt_q <= '0;
            force_q    <= 1'b1;
            buf_sel_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            recv_cnt_q <= recv_cnt_d;
            force_q    <= force_d;
            buf_sel_q  <= buf_sel_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        wr_line_w.is_vert = res_is_vert_in;
        wr_line_w.height  = res_height_in;
    end

    assign wr_en_out   = res_acc_w;
    assign wr_addr_out = res_acc_w ? {~buf_sel_q, res_col_in} : '0;
    assign wr_data_out = res_acc_w ? wr_line_w : '0;
    assign buf_sel_out = buf_sel_q;
    assign busy_out    = (state_q != S_IDLE);
    assign done_out    = (state_q == S_SWAP);
    assign overrun_out = overrun_q;

endmodule
